// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative MULU (shift-add)
// and optional DIVU (restoring), one bit per cycle. Define ALU_MC_DIV_EN to build the divider.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       Aluc,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] H,
  output logic             Z,
  output logic             V,
  output logic             DivZ,
  output logic             o_dbg_state
);

  // Handshake: Start is accepted on a rising edge only while Busy=0; Done is a
  // one-cycle pulse marking the cycle in which R/H/flags carry a new result.

  localparam int             HALF     = WIDTH / 2;
  localparam int             MSB      = WIDTH - 1;
  localparam logic [SHW:0]   LP_ITERS = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]   LP_ONE   = (SHW+1)'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ITER = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [SHW:0]     r_cnt;
  logic [SHW:0]     w_cnt_nxt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_done, r_z, r_v, r_divz;
  logic [WIDTH-1:0] r_r, r_h;

  logic             w_accept, w_is_mul, w_is_div, w_go_iter, w_last;
  logic [WIDTH-1:0] w_add, w_sub, w_sra;
  logic [WIDTH-1:0] w_sc_r, w_sc_h;
  logic             w_sc_v, w_sc_divz;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_step_hi, w_step_lo;
`ifdef ALU_MC_DIV_EN
  logic             r_op_div;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_rem_sub;
  logic             w_ge;
`endif

  assign w_accept  = Start && (r_state == ST_IDLE);
  assign w_is_mul  = (Aluc == 4'b1000);
`ifdef ALU_MC_DIV_EN
  assign w_is_div  = (Aluc == 4'b1100) && (Y != '0);
`else
  assign w_is_div  = 1'b0;
`endif
  assign w_go_iter = w_accept && (w_is_mul || w_is_div);
  assign w_cnt_nxt = r_cnt + LP_ONE;
  assign w_last    = (r_state == ST_ITER) && (w_cnt_nxt == LP_ITERS);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go_iter) w_state_nxt = ST_ITER;
      ST_ITER: if (w_last)    w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_add = X + Y;
  assign w_sub = X - Y;
  assign w_sra = $unsigned($signed(Y) >>> X[SHW-1:0]);

  always_comb begin
    w_sc_r    = '0;
    w_sc_h    = '0;
    w_sc_v    = 1'b0;
    w_sc_divz = 1'b0;
    case (Aluc)
      4'b0000: begin
        w_sc_r = w_add;
        w_sc_v = (X[MSB] == Y[MSB]) && (w_add[MSB] != X[MSB]);
      end
      4'b0100: begin
        w_sc_r = w_sub;
        w_sc_v = (X[MSB] != Y[MSB]) && (w_sub[MSB] != X[MSB]);
      end
      4'b0001, 4'b1001: w_sc_r = X & Y;
      4'b0101, 4'b1101: w_sc_r = X | Y;
      4'b0010, 4'b1010: w_sc_r = X ^ Y;
      4'b0110, 4'b1110: w_sc_r = {Y[HALF-1:0], {HALF{1'b0}}};
      4'b0011:          w_sc_r = Y << X[SHW-1:0];
      4'b0111:          w_sc_r = Y >> X[SHW-1:0];
      4'b1111:          w_sc_r = w_sra;
`ifdef ALU_MC_DIV_EN
      // Only a zero divisor reaches the single-cycle path for DIVU.
      4'b1100: begin
        w_sc_r    = '1;
        w_sc_h    = X;
        w_sc_divz = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Shared {r_hi, r_lo} pair: product shifts right for MULU, quotient shifts left for DIVU.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
`ifdef ALU_MC_DIV_EN
  assign w_rem_sh  = {r_hi, r_lo[MSB]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
`endif

  always_comb begin
    w_step_hi = w_mul_sum[WIDTH:1];
    w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
    if (r_op_div) begin
      w_step_hi = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_ge};
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_done <= 1'b0;
      r_r    <= '0;
      r_h    <= '0;
      r_z    <= 1'b1;
      r_v    <= 1'b0;
      r_divz <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
`ifdef ALU_MC_DIV_EN
      r_op_div <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_go_iter) begin
        r_cnt <= '0;
        r_hi  <= '0;
        r_lo  <= w_is_mul ? Y : X;
        r_b   <= w_is_mul ? X : Y;
`ifdef ALU_MC_DIV_EN
        r_op_div <= !w_is_mul;
`endif
      end else if (w_accept) begin
        r_done <= 1'b1;
        r_r    <= w_sc_r;
        r_h    <= w_sc_h;
        r_z    <= (w_sc_r == '0);
        r_v    <= w_sc_v;
        r_divz <= w_sc_divz;
      end else if (r_state == ST_ITER) begin
        r_cnt <= w_cnt_nxt;
        r_hi  <= w_step_hi;
        r_lo  <= w_step_lo;
        if (w_last) begin
          r_done <= 1'b1;
          r_r    <= w_step_lo;
          r_h    <= w_step_hi;
          r_z    <= (w_step_lo == '0);
          r_v    <= 1'b0;
          r_divz <= 1'b0;
        end
      end
    end
  end

  assign Busy        = (r_state == ST_ITER);
  assign Done        = r_done;
  assign R           = r_r;
  assign H           = r_h;
  assign Z           = r_z;
  assign V           = r_v;
  assign DivZ        = r_divz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): cycle-level behavioural model plus directed literal checks.
module tb_alu_mc;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          Rst, Start;
  logic [W-1:0]  X, Y;
  logic [3:0]    Aluc;
  logic          Busy, Done, Z, V, DivZ, dbg_state;
  logic [W-1:0]  R, H;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .X(X), .Y(Y), .Aluc(Aluc),
    .Busy(Busy), .Done(Done), .R(R), .H(H), .Z(Z), .V(V), .DivZ(DivZ),
    .o_dbg_state(dbg_state)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         v;
    logic         divz;
  } res_t;

  function automatic bit is_iter(input logic [3:0] a, input logic [W-1:0] y);
`ifdef ALU_MC_DIV_EN
    return (a == 4'b1000) || (a == 4'b1100 && y != 0);
`else
    return (a == 4'b1000) && (y === y);
`endif
  endfunction

  function automatic res_t model_op(input logic [3:0] a, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t o;
    longint sx, sy, s;
    logic [63:0] p;
    logic signed [W-1:0] ys;
    int sh;
    o = '{r: '0, h: '0, v: 1'b0, divz: 1'b0};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ys = y;
    sh = int'(x[4:0]);
    case (a)
      4'b0000: begin o.r = x + y; s = sx + sy; o.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0100: begin o.r = x - y; s = sx - sy; o.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0001, 4'b1001: o.r = x & y;
      4'b0101, 4'b1101: o.r = x | y;
      4'b0010, 4'b1010: o.r = x ^ y;
      4'b0110, 4'b1110: o.r = {y[15:0], 16'h0000};
      4'b0011: o.r = y << sh;
      4'b0111: o.r = y >> sh;
      4'b1111: o.r = ys >>> sh;
      4'b1000: begin p = {32'h0, x} * {32'h0, y}; o.r = p[31:0]; o.h = p[63:32]; end
`ifdef ALU_MC_DIV_EN
      4'b1100: begin
        if (y == 0) begin o.r = '1; o.h = x; o.divz = 1'b1; end
        else begin o.r = x / y; o.h = x % y; end
      end
`endif
      default: ;
    endcase
    return o;
  endfunction

  int   m_left = 0;
  bit   m_done = 1'b0;
  res_t m_res;
  res_t m_pend;

  always @(posedge Clk) begin
    if (Rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= '{r: '0, h: '0, v: 1'b0, divz: 1'b0};
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) m_res <= m_pend;
    end else if (Start) begin
      if (is_iter(Aluc, Y)) begin
        m_left <= W;
        m_done <= 1'b0;
        m_pend <= model_op(Aluc, X, Y);
      end else begin
        m_done <= 1'b1;
        m_res  <= model_op(Aluc, X, Y);
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge Clk);
      if (check_en) begin
        n_vec++;
        if ({Busy, dbg_state, Done, R, H, Z, V, DivZ} !==
            {(m_left > 0), (m_left > 0), m_done, m_res.r, m_res.h, (m_res.r == 0), m_res.v, m_res.divz}) begin
          n_err++;
          $display("FAIL cycle @%0t busy/st/done/R/H/Z/V/DivZ got %b %b %b %h %h %b %b %b want %b %b %b %h %h %b %b %b",
                   $time, Busy, dbg_state, Done, R, H, Z, V, DivZ,
                   (m_left > 0), (m_left > 0), m_done, m_res.r, m_res.h, (m_res.r == 0), m_res.v, m_res.divz);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit rst, input bit s, input logic [3:0] a,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    Rst = rst; Start = s; Aluc = a; X = x; Y = y;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!Done && cyc < 100) begin
      step(1'b0, 1'b0, 4'h0, '0, '0);
      cyc++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [3:0] a;
    logic [W-1:0] rx, ry;

    Rst = 1'b1; Start = 1'b0; Aluc = '0; X = '0; Y = '0;
    repeat (3) step(1'b1, 1'b0, 4'h0, '0, '0);
    check_en = 1'b1;
    chk("reset_r", R, 0);
    chk("reset_h", H, 0);
    chk("reset_z", Z, 1);
    chk("reset_busy_done", {Busy, Done, V, DivZ}, 0);

    // signed overflow on add
    step(1'b0, 1'b1, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    chk("add_ovf_done", Done, 1);
    chk("add_ovf_r", R, 64'h8000_0000);
    chk("add_ovf_vz", {V, Z, Busy}, 3'b100);

    // arithmetic shift and lui
    step(1'b0, 1'b1, 4'b1111, 32'd4, 32'h8000_0000);
    chk("sra_r", R, 64'hF800_0000);
    step(1'b0, 1'b1, 4'b0110, 32'd0, 32'h0000_1234);
    chk("lui_r", R, 64'h1234_0000);
    chk("lui_h", H, 0);

    // MULU max operands with Start pulses ignored while busy
    step(1'b0, 1'b1, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulu_busy", Busy, 1);
    cyc = 1;
    while (!Done && cyc < 100) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, $urandom);
      cyc++;
    end
    chk("mulu_latency", 64'(cyc), 33);
    chk("mulu_r", R, 64'h0000_0001);
    chk("mulu_h", H, 64'hFFFF_FFFE);

    // back-to-back issue on the Done cycle
    step(1'b0, 1'b1, 4'b0100, 32'd3, 32'd3);
    chk("b2b_done", Done, 1);
    chk("b2b_rz", {R, Z}, {32'h0, 1'b1});

`ifdef ALU_MC_DIV_EN
    step(1'b0, 1'b1, 4'b1100, 32'd100, 32'd7);
    wait_done(cyc);
    chk("divu_latency", 64'(cyc), 33);
    chk("divu_r", R, 14);
    chk("divu_h", H, 2);
    step(1'b0, 1'b1, 4'b1100, 32'd5, 32'd0);
    chk("divz_done_busy", {Done, Busy}, 2'b10);
    chk("divz_r", R, 64'hFFFF_FFFF);
    chk("divz_h", H, 5);
    chk("divz_flag", DivZ, 1);
`else
    step(1'b0, 1'b1, 4'b1100, 32'd100, 32'd7);
    chk("divu_rsvd_done_busy", {Done, Busy}, 2'b10);
    chk("divu_rsvd_rh", {R, H}, 0);
    chk("divu_rsvd_divz", DivZ, 0);
`endif

    // reset abort in the middle of a multiply
    step(1'b0, 1'b1, 4'b1000, $urandom, $urandom);
    repeat (9) step(1'b0, 1'b0, 4'h0, '0, '0);
    chk("abort_busy_before", Busy, 1);
    step(1'b1, 1'b1, 4'b1000, 32'd9, 32'd9);
    chk("abort_state", {Busy, Done, V, DivZ, Z}, 5'b00001);
    chk("abort_rh", {R, H}, 0);
    step(1'b0, 1'b1, 4'b0000, 32'd1, 32'd2);
    chk("after_abort_done", Done, 1);
    chk("after_abort_r", R, 3);
    repeat (35) step(1'b0, 1'b0, 4'h0, '0, '0);
    chk("abort_no_late_done", Done, 0);

    // randomized traffic; per-cycle compare checks every cycle against the model
    for (int i = 0; i < 600; i++) begin
      a  = ($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? 4'b1000 : 4'b1100)
                                       : 4'($urandom_range(0, 15));
      rx = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 40)) : $urandom;
      ry = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom;
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0), a, rx, ry);
    end
    repeat (40) step(1'b0, 1'b0, 4'h0, '0, '0);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
